// File: rtl/simon_pkg.sv
// simon_pkg: shared definitions for the Simon presentation path.
//   - color code constants (RED=1, BLUE=2, YELLOW=3, GREEN=4)
//   - one-hot 4-bit FSM state encodings
//   - led_decode(): code -> one-hot LED pattern, also used by the VGA color block
//   - code_valid(): true for the four legal codes
package simon_pkg;

    typedef logic [2:0] color_t;

    localparam color_t RED    = 3'd1;
    localparam color_t BLUE   = 3'd2;
    localparam color_t YELLOW = 3'd3;
    localparam color_t GREEN  = 3'd4;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_SHOW = 4'b0010;
    localparam logic [3:0] ST_GAP  = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;

    // led[0]=RED, led[1]=BLUE, led[2]=YELLOW, led[3]=GREEN; illegal codes stay dark.
    function automatic logic [3:0] led_decode(input color_t code);
        case (code)
            RED:     return 4'b0001;
            BLUE:    return 4'b0010;
            YELLOW:  return 4'b0100;
            GREEN:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic code_valid(input color_t code);
        return (led_decode(code) != 4'b0000);
    endfunction

endpackage

// File: rtl/simon_sequence_player_if.sv
// simon_sequence_player_if: bundle between the game controller (master) and
// the sequence player (slave).
//   Start, Abort, level, colors : controller -> player
//   led, color, step, Busy, Done, Err, state : player -> controller / drivers
//
// Handshake: Start is level-sampled and only accepted while the player is
// idle; there is no ready signal, the controller uses Busy to know a request
// is in flight and Done (one-cycle pulse) to know playback has finished.
// Abort wins over Start in the same cycle. colors/level are captured on the
// accepting edge and ignored afterwards.
interface simon_sequence_player_if #(
    parameter int MAX_LEN = 10
);
    logic                   Start;
    logic                   Abort;
    logic [6:0]             level;
    logic [3*MAX_LEN-1:0]   colors;
    logic [3:0]             led;
    logic [2:0]             color;
    logic [3:0]             step;
    logic                   Busy;
    logic                   Done;
    logic                   Err;
    logic [3:0]             state;  // debug view of the FSM state

    modport master (
        output Start, Abort, level, colors,
        input  led, color, step, Busy, Done, Err, state
    );

    modport slave (
        input  Start, Abort, level, colors,
        output led, color, step, Busy, Done, Err, state
    );
endinterface

// File: rtl/simon_phase_timer.sv
// simon_phase_timer: loadable down-counter timing the lit and dark phases.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : phase length minus one
//   en         : count down while the phase is running
//   expire     : high on the last cycle of the loaded phase
module simon_phase_timer
    import simon_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = en && (cnt_q == '0);
endmodule

// File: rtl/simon_sequence_player.sv
// simon_sequence_player: plays a latched sequence of color codes, one color
// lit for ON_CYCLES followed by OFF_CYCLES dark, then pulses Done.
//   Clk   : system clock (rising edge)
//   Reset : asynchronous active-low reset
//   bus   : simon_sequence_player_if slave (Start/Abort/level/colors in;
//           led/color/step/Busy/Done/Err/state out, all registered)
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 10,
    parameter int ON_CYCLES  = 50000000,
    parameter int OFF_CYCLES = 25000000,
    parameter int CNT_W      = 26
) (
    input  logic Clk,
    input  logic Reset,
    simon_sequence_player_if.slave bus
);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    logic [3:0]           state_q;
    logic [3*MAX_LEN-1:0] seq_q;
    logic [3:0]           len_q;
    logic [3:0]           step_q;
    logic [3:0]           led_q;
    logic [2:0]           color_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic [3:0]           len_in;
    logic [3:0]           next_idx;
    color_t               first_code;
    color_t               next_code;
    logic                 last_step;
    logic                 timer_load;
    logic [CNT_W-1:0]     timer_val;
    logic                 timer_en;
    logic                 expire;

    always_comb begin
        len_in     = (bus.level > 7'(MAX_LEN)) ? 4'(MAX_LEN) : bus.level[3:0];
        first_code = bus.colors[2:0];
        next_idx   = step_q + 4'd1;
        last_step  = (step_q == len_q - 4'd1);
        next_code  = 3'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (next_idx == i[3:0]) next_code = seq_q[3*i +: 3];
        end

        timer_load = 1'b0;
        timer_val  = ON_LOAD;
        timer_en   = ((state_q == ST_SHOW) || (state_q == ST_GAP)) && !bus.Abort;
        if (!bus.Abort) begin
            case (state_q)
                ST_IDLE: timer_load = bus.Start && (len_in != 4'd0);
                ST_SHOW: begin
                    timer_load = expire;
                    timer_val  = OFF_LOAD;
                end
                ST_GAP:  timer_load = expire && !last_step;
                default: timer_load = 1'b0;
            endcase
        end
    end

    simon_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .expire   (expire)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            led_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.Abort) begin
            // Drop straight to idle; Err and step are left as they were.
            state_q <= ST_IDLE;
            led_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        seq_q  <= bus.colors;
                        len_q  <= len_in;
                        step_q <= 4'd0;
                        if (len_in == 4'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= ST_SHOW;
                            busy_q  <= 1'b1;
                            led_q   <= led_decode(first_code);
                            color_q <= code_valid(first_code) ? first_code : 3'd0;
                            err_q   <= !code_valid(first_code);
                        end
                    end
                end
                ST_SHOW: begin
                    if (expire) begin
                        state_q <= ST_GAP;
                        led_q   <= '0;
                        color_q <= '0;
                    end
                end
                ST_GAP: begin
                    if (expire) begin
                        if (last_step) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHOW;
                            step_q  <= next_idx;
                            led_q   <= led_decode(next_code);
                            color_q <= code_valid(next_code) ? next_code : 3'd0;
                            err_q   <= err_q | !code_valid(next_code);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led   = led_q;
    assign bus.color = color_q;
    assign bus.step  = step_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.Err   = err_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_simon_sequence_player.sv
// tb_simon_sequence_player: scenario tasks driving simon_sequence_player with
// ON_CYCLES=3, OFF_CYCLES=2, MAX_LEN=10. Expected per-cycle traces come from a
// list-of-phases model of the playback rules.
module tb_simon_sequence_player;
    import simon_pkg::*;

    localparam int MAX_LEN = 10;
    localparam int ON      = 3;
    localparam int OFF     = 2;

    // clock / reset
    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    simon_sequence_player_if #(.MAX_LEN(MAX_LEN)) bus ();

    simon_sequence_player #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .CNT_W      (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // scoreboard: {Busy, Done, led[3:0], color[2:0]} per cycle
    logic [8:0] exp_q[$];

    function automatic logic [3:0] model_led(input int code);
        if (code >= 1 && code <= 4) return 4'b0001 << (code - 1);
        return 4'b0000;
    endfunction

    function automatic logic [8:0] observed();
        return {bus.Busy, bus.Done, bus.led, bus.color};
    endfunction

    // Builds the expected trace from the first cycle after the accepting edge
    // up to and including the idle cycle following Done; returns expected Err.
    function automatic logic build_model(input logic [6:0] lvl, input logic [29:0] cols);
        int  len;
        int  code;
        logic err;
        exp_q.delete();
        err = 1'b0;
        len = (int'(lvl) > MAX_LEN) ? MAX_LEN : int'(lvl);
        for (int s = 0; s < len; s++) begin
            code = int'((cols >> (3*s)) & 30'h7);
            if (model_led(code) == 4'b0000) err = 1'b1;
            for (int c = 0; c < ON; c++)
                exp_q.push_back({1'b1, 1'b0, model_led(code),
                                 (model_led(code) != 0) ? 3'(code) : 3'd0});
            for (int c = 0; c < OFF; c++)
                exp_q.push_back({1'b1, 1'b0, 4'b0000, 3'd0});
        end
        exp_q.push_back({1'b0, 1'b1, 4'b0000, 3'd0});
        exp_q.push_back({1'b0, 1'b0, 4'b0000, 3'd0});
        return err;
    endfunction

    // driver + checker for one full playback; inject_at>0 raises a second
    // Start (with different colors) on that cycle of the playback
    task automatic run_playback(input string name, input logic [6:0] lvl,
                                input logic [29:0] cols, input int inject_at);
        logic       exp_err;
        logic [8:0] exp_v;
        int         len;
        int         cyc;
        exp_err = build_model(lvl, cols);
        len = (int'(lvl) > MAX_LEN) ? MAX_LEN : int'(lvl);
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.level  = lvl;
        bus.colors = cols;
        @(negedge Clk);
        bus.Start = 1'b0;
        cyc = 1;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            total++;
            if (observed() !== exp_v) begin
                bad++;
                $display("FAIL %s cycle %0d: got busy/done/led/color=%b want %b",
                         name, cyc, observed(), exp_v);
            end
            if (inject_at > 0 && cyc == inject_at) begin
                bus.Start  = 1'b1;
                bus.colors = ~cols;
            end else if (inject_at > 0 && cyc == inject_at + 1) begin
                bus.Start  = 1'b0;
                bus.colors = cols;
            end
            cyc++;
            @(negedge Clk);
        end
        total++;
        if (bus.Err !== exp_err) begin
            bad++;
            $display("FAIL %s err: got %b want %b", name, bus.Err, exp_err);
        end
        if (len > 0) begin
            total++;
            if (bus.step !== 4'(len - 1)) begin
                bad++;
                $display("FAIL %s final_step: got %0d want %0d", name, bus.step, len - 1);
            end
        end
    endtask

    task automatic check_dark(input string name);
        total++;
        if ({bus.led, bus.color, bus.step, bus.Busy, bus.Done, bus.Err, bus.state} !==
            {4'b0, 3'b0, 4'b0, 1'b0, 1'b0, 1'b0, ST_IDLE}) begin
            bad++;
            $display("FAIL %s: got led=%b color=%0d step=%0d busy=%b done=%b err=%b state=%b want all zero, state IDLE",
                     name, bus.led, bus.color, bus.step, bus.Busy, bus.Done, bus.Err, bus.state);
        end
    endtask

    task automatic test_reset();
        bus.Start  = 1'b0;
        bus.Abort  = 1'b0;
        bus.level  = '0;
        bus.colors = '0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_dark("reset_state");
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        run_playback("basic", 7'd3, {21'd0, 3'd3, 3'd2, 3'd1}, 0);
    endtask

    task automatic test_zero_and_clamp();
        logic [29:0] cols;
        run_playback("level_zero", 7'd0, {21'd0, 3'd3, 3'd2, 3'd1}, 0);
        for (int i = 0; i < MAX_LEN; i++) cols[3*i +: 3] = 3'((i % 4) + 1);
        run_playback("clamp_15", 7'd15, cols, 0);
    endtask

    task automatic test_invalid_code();
        run_playback("invalid_code", 7'd2, {24'd0, 3'd7, 3'd1}, 0);
        run_playback("err_clear", 7'd2, {24'd0, 3'd4, 3'd3}, 0);
    endtask

    task automatic test_start_during_playback();
        run_playback("start_ignored", 7'd3, {21'd0, 3'd1, 3'd4, 3'd2}, 4);
    endtask

    task automatic test_abort();
        int stray;
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.level  = 7'd3;
        bus.colors = {21'd0, 3'd3, 3'd2, 3'd1};
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (6) @(negedge Clk);  // cycle 7: second cycle of step 1 SHOW
        total++;
        if (bus.led !== 4'b0010 || bus.Busy !== 1'b1 || bus.step !== 4'd1) begin
            bad++;
            $display("FAIL abort_pre: got led=%b busy=%b step=%0d want 0010 1 1",
                     bus.led, bus.Busy, bus.step);
        end
        bus.Abort = 1'b1;
        bus.Start = 1'b1;  // Abort must win
        @(negedge Clk);
        bus.Abort = 1'b0;
        bus.Start = 1'b0;
        total++;
        if (bus.led !== 4'b0 || bus.color !== 3'd0 || bus.Busy !== 1'b0 ||
            bus.Done !== 1'b0 || bus.state !== ST_IDLE) begin
            bad++;
            $display("FAIL abort_now: got led=%b color=%0d busy=%b done=%b state=%b want 0 0 0 0 %b",
                     bus.led, bus.color, bus.Busy, bus.Done, bus.state, ST_IDLE);
        end
        stray = 0;
        repeat (10) begin
            @(negedge Clk);
            if (bus.Done !== 1'b0 || bus.led !== 4'b0 || bus.Busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", stray);
        end
        run_playback("after_abort", 7'd2, {24'd0, 3'd2, 3'd4}, 0);
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.level  = 7'd2;
        bus.colors = {24'd0, 3'd2, 3'd6};  // invalid step 0 sets Err
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge Clk);  // cycle 4: GAP of step 0
        total++;
        if (bus.Busy !== 1'b1 || bus.led !== 4'b0 || bus.Err !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre: got busy=%b led=%b err=%b want 1 0000 1",
                     bus.Busy, bus.led, bus.Err);
        end
        #2 Reset = 1'b0;
        #1 check_dark("async_reset");
        @(negedge Clk);
        Reset = 1'b1;
        run_playback("after_reset", 7'd2, {24'd0, 3'd3, 3'd1}, 0);
    endtask

    task automatic test_random();
        logic [29:0] cols;
        logic [6:0]  lvl;
        for (int r = 0; r < 8; r++) begin
            lvl = 7'($urandom_range(0, 14));
            for (int i = 0; i < MAX_LEN; i++)
                cols[3*i +: 3] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                              : 3'($urandom_range(1, 4));
            run_playback($sformatf("random_%0d", r), lvl, cols, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_clamp();
        test_invalid_code();
        test_start_during_playback();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
